mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage load/store controller that drives the external data-memory bus and produces the memory-stage results consumed by the memory/write-back pipeline register. It accepts a load or store from the execute/memory pipeline register and runs a req/ack handshake with data memory. It stalls the pipeline until the access completes, then presents the load data as `ReadDataM` for capture into the write-back stage.

## Interface
- `TIMEOUT_CYCLES`, 15: cycles in REQ without `MemAck` before abort (timeout build only); range 1..255.
- `CLK` input 1: single clock; all state updates on rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `MemtoRegM` input 1: current memory-stage instruction is a load.
- `MemWriteM` input 1: current memory-stage instruction is a store; wins if both set.
- `ALUOutM` input 32: byte address of the access.
- `WriteDataM` input 32: store data.
- `ReadDataM` output 32: registered load data for the memory/write-back register.
- `StallM` output 1: combinational; freezes fetch through the memory stage.
- `MemReq` output 1: registered bus request.
- `MemWE` output 1: registered; 1 = write, 0 = read.
- `MemAddr` output 32: registered word address, `{ALUOutM[31:2],2'b00}`.
- `MemWData` output 32: registered write data.
- `MemRData` input 32: read data, valid when `MemAck`=1.
- `MemAck` input 1: one-cycle completion pulse from memory.
- `BusFault` output 1: sticky timeout flag; constant 0 without timeout build.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if `MemtoRegM|MemWriteM`, latch `MemWE=MemWriteM`, `MemAddr`, `MemWData`; set `MemReq`=1; go REQ. Otherwise stay.
- REQ: hold `MemReq` and bus outputs stable. On `MemAck`=1: drop `MemReq`. If the access is a read (`MemWE`=0), load `ReadDataM<=MemRData`. Go DONE.
- DONE: unconditionally go IDLE. M-stage inputs are ignored, so the same instruction is never re-issued.
- `StallM = (IDLE & (MemtoRegM|MemWriteM)) | REQ`. `StallM` is 0 in DONE, so the pipeline advances at the end of DONE.
- `ReadDataM` changes only on a read ack, or on timeout abort in the timeout build. Otherwise it holds its value, including across stores.
- `MemAck` outside REQ is ignored.
- Address bits [1:0] are dropped; only word accesses are supported.
- Both `MemtoRegM` and `MemWriteM` set: the access is performed as a store and `ReadDataM` is not updated.

## Timing
- Reset values: state IDLE, `ReadDataM`=0, `MemReq`=0, `MemWE`=0, `MemAddr`=0, `MemWData`=0, `BusFault`=0.
- `StallM` follows the inputs combinationally even during reset (state is IDLE).
- Access detected in IDLE at cycle t: `MemReq` is high from t+1.
- With ack at cycle t+k (k≥1): DONE at t+k+1, and `ReadDataM` is valid from t+k+1. The minimum is 2 stall cycles.
- Back-to-back accesses: IDLE → REQ → DONE → IDLE. The next access issues from IDLE one cycle after DONE, giving 3 cycles per access minimum.
- Reset asserted mid-access: all outputs go to reset values immediately and `MemReq` drops asynchronously. The memory must discard the aborted transaction.

## Configuration
- `MEM_ACCESS_TIMEOUT_EN` defined: an 8-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, the unit drops `MemReq` and sets `BusFault`=1. `BusFault` stays set until `Reset`.
  - On a read abort, `ReadDataM` is loaded with 32'hDEADBEEF. The unit then goes to DONE.
  - An ack in the same cycle as the counter reaching the limit wins, and no fault is raised.
- `MEM_ACCESS_TIMEOUT_EN` undefined: REQ waits indefinitely and `BusFault` is tied to 0.

## Test plan
- Load: `MemtoRegM`=1, `ALUOutM`=32'h0000_0106, `MemAck` returned 1 cycle after `MemReq` with `MemRData`=32'hCAFEF00D.
  - `MemAddr`=32'h0000_0104, `MemWE`=0, `StallM` high for exactly 2 cycles.
  - `ReadDataM`=32'hCAFEF00D in DONE.
- Store with 4-cycle ack delay, `WriteDataM`=32'h12345678.
  - `MemWE`=1 and `MemWData`=32'h12345678 held stable for 4 cycles.
  - `StallM` high for 5 cycles; `ReadDataM` unchanged.
- Back-to-back load then store, each acked immediately: two separate `MemReq` pulses with one DONE+IDLE gap, and no reissue of the load.
- Reset mid-REQ: `MemReq`, `MemAddr` and `ReadDataM` go to 0 before the next clock edge. A late `MemAck` after reset is ignored and the FSM stays in IDLE.
- Both `MemtoRegM` and `MemWriteM` set, ack with `MemRData`=32'hFFFFFFFF: a store is performed and `ReadDataM` keeps its prior value.
- Timeout build, `TIMEOUT_CYCLES`=15, no ack on a load:
  - `MemReq` drops after 15 REQ cycles and `BusFault`=1.
  - `ReadDataM`=32'hDEADBEEF; the next access proceeds normally with `BusFault` still 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store controller: req/ack handshake with data memory, pipeline stall, load-data capture.
// Optional build macro MEM_ACCESS_TIMEOUT_EN adds a REQ timeout with sticky BusFault.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        BusFault
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic       access;

  // Only word accesses exist, so the byte offset is deliberately discarded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^ALUOutM[1:0];

  assign access = MemtoRegM | MemWriteM;
  assign StallM = ((state == IDLE) & access) | (state == REQ);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign BusFault = 1'b0;
`endif

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ReadDataM <= 32'h0;
      MemReq    <= 1'b0;
      MemWE     <= 1'b0;
      MemAddr   <= 32'h0;
      MemWData  <= 32'h0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wait_cnt  <= 8'h0;
      BusFault  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            MemWE    <= MemWriteM;
            MemAddr  <= {ALUOutM[31:2], 2'b00};
            MemWData <= WriteDataM;
            MemReq   <= 1'b1;
            state    <= REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt <= 8'h0;
`endif
          end
        end
        REQ: begin
          // An ack always beats a timeout landing in the same cycle.
          if (MemAck) begin
            MemReq <= 1'b0;
            if (!MemWE) ReadDataM <= MemRData;
            state <= DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (wait_cnt + 8'd1 == TO_LIM) begin
            wait_cnt <= wait_cnt + 8'd1;
            MemReq   <= 1'b0;
            BusFault <= 1'b1;
            if (!MemWE) ReadDataM <= 32'hDEADBEEF;
            state    <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        // DONE ignores the M-stage inputs so a stalled instruction is never reissued.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level reference model checked every cycle plus literal checks.
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        MemtoRegM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUOutM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = 32'h0;
  logic        MemAck = 1'b0;
  logic        BusFault;

  int errs = 0;
  int checks = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .Reset(Reset), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .BusFault(BusFault)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access, an ack (or timeout) completes it,
  // then exactly one dead cycle during which new requests are not taken.
  logic        m_busy, m_cool, m_we, m_fault;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_wait;

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      m_busy <= 1'b0; m_cool <= 1'b0; m_we <= 1'b0; m_fault <= 1'b0;
      m_addr <= 32'h0; m_wdata <= 32'h0; m_rdata <= 32'h0; m_wait <= 0;
    end else if (m_cool) begin
      m_cool <= 1'b0;
    end else if (m_busy) begin
      if (MemAck) begin
        m_busy <= 1'b0; m_cool <= 1'b1;
        if (!m_we) m_rdata <= MemRData;
      end
`ifdef MEM_ACCESS_TIMEOUT_EN
      else if (m_wait + 1 == TO) begin
        m_busy <= 1'b0; m_cool <= 1'b1; m_fault <= 1'b1;
        if (!m_we) m_rdata <= 32'hDEADBEEF;
      end else begin
        m_wait <= m_wait + 1;
      end
`endif
    end else if (MemtoRegM | MemWriteM) begin
      m_busy  <= 1'b1;
      m_we    <= MemWriteM;
      m_addr  <= {ALUOutM[31:2], 2'b00};
      m_wdata <= WriteDataM;
      m_wait  <= 0;
    end
  end

  always @(negedge CLK) begin
    chk("MemReq", {31'h0, MemReq}, {31'h0, m_busy});
    chk("MemWE", {31'h0, MemWE}, {31'h0, m_we});
    chk("MemAddr", MemAddr, m_addr);
    chk("MemWData", MemWData, m_wdata);
    chk("ReadDataM", ReadDataM, m_rdata);
    chk("BusFault", {31'h0, BusFault}, {31'h0, m_fault});
    chk("StallM", {31'h0, StallM},
        {31'h0, m_busy | (!m_busy & !m_cool & (MemtoRegM | MemWriteM))});
  end

  // Called at posedge+1 with the FSM idle; returns at posedge+1 after DONE.
  task automatic run_access(input logic ld, input logic st, input logic [31:0] addr,
                            input logic [31:0] wd, input int k, input logic [31:0] rd,
                            output int stalls, output logic [31:0] req_addr,
                            output logic req_we, output logic [31:0] done_rdata);
    stalls = 0;
    req_addr = 32'h0;
    req_we = 1'b0;
    MemtoRegM = ld; MemWriteM = st; ALUOutM = addr; WriteDataM = wd;
    @(negedge CLK); if (StallM) stalls++;
    @(posedge CLK); #1;
    for (int j = 1; j <= k; j++) begin
      if (j == k) begin MemAck = 1'b1; MemRData = rd; end
      @(negedge CLK); if (StallM) stalls++;
      if (j == 1) begin req_addr = MemAddr; req_we = MemWE; end
      if (st) begin
        chk("we_hold", {31'h0, MemWE}, 32'h1);
        chk("wdata_hold", MemWData, wd);
      end
      @(posedge CLK); #1;
      MemAck = 1'b0; MemRData = 32'h0;
    end
    @(negedge CLK); if (StallM) stalls++;
    done_rdata = ReadDataM;
    @(posedge CLK); #1;
    MemtoRegM = 1'b0; MemWriteM = 1'b0;
  endtask

  int          stalls;
  logic [31:0] ra, rdv;
  logic        rwe;

  initial begin
    #1 Reset = 1'b1;
    #1;
    chk("rst_MemReq", {31'h0, MemReq}, 32'h0);
    chk("rst_ReadDataM", ReadDataM, 32'h0);
    chk("rst_MemAddr", MemAddr, 32'h0);
    chk("rst_BusFault", {31'h0, BusFault}, 32'h0);
    MemWriteM = 1'b1; #1;
    chk("rst_StallM_comb", {31'h0, StallM}, 32'h1);
    MemWriteM = 1'b0; #1;
    chk("rst_StallM_idle", {31'h0, StallM}, 32'h0);
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;
    @(posedge CLK); #1;

    // Load, ack in the first REQ cycle
    run_access(1'b1, 1'b0, 32'h0000_0106, 32'h0, 1, 32'hCAFEF00D, stalls, ra, rwe, rdv);
    chk("load_addr", ra, 32'h0000_0104);
    chk("load_we", {31'h0, rwe}, 32'h0);
    chk("load_stalls", stalls, 32'd2);
    chk("load_rdata", rdv, 32'hCAFEF00D);

    // Store, ack after 4 REQ cycles
    run_access(1'b0, 1'b1, 32'h0000_0040, 32'h12345678, 4, 32'h55AA55AA, stalls, ra, rwe, rdv);
    chk("store_we", {31'h0, rwe}, 32'h1);
    chk("store_stalls", stalls, 32'd5);
    chk("store_rdata_kept", rdv, 32'hCAFEF00D);

    // Back-to-back load then store
    run_access(1'b1, 1'b0, 32'h0000_0203, 32'h0, 1, 32'h11223344, stalls, ra, rwe, rdv);
    chk("b2b_load_rdata", rdv, 32'h11223344);
    chk("b2b_load_addr", ra, 32'h0000_0200);
    run_access(1'b0, 1'b1, 32'h0000_0208, 32'hA5A5_0001, 1, 32'h0, stalls, ra, rwe, rdv);
    chk("b2b_store_addr", ra, 32'h0000_0208);
    chk("b2b_store_stalls", stalls, 32'd2);

    // Both load and store flags: performed as a store
    run_access(1'b1, 1'b1, 32'h0000_0300, 32'h0BADC0DE, 1, 32'hFFFFFFFF, stalls, ra, rwe, rdv);
    chk("both_we", {31'h0, rwe}, 32'h1);
    chk("both_rdata_kept", rdv, 32'h11223344);

    // Reset in the middle of REQ
    MemtoRegM = 1'b1; ALUOutM = 32'h0000_0500;
    @(posedge CLK); #1;
    MemtoRegM = 1'b0;
    chk("pre_rst_req", {31'h0, MemReq}, 32'h1);
    #2 Reset = 1'b1;
    #1;
    chk("midrst_MemReq", {31'h0, MemReq}, 32'h0);
    chk("midrst_MemAddr", MemAddr, 32'h0);
    chk("midrst_ReadDataM", ReadDataM, 32'h0);
    @(posedge CLK); #1 Reset = 1'b0;
    MemAck = 1'b1; MemRData = 32'h77777777;
    @(posedge CLK); #1;
    MemAck = 1'b0;
    chk("late_ack_MemReq", {31'h0, MemReq}, 32'h0);
    chk("late_ack_rdata", ReadDataM, 32'h0);
    @(posedge CLK); #1;
    chk("late_ack_idle", {31'h0, MemReq}, 32'h0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int n;
      n = 0;
      MemtoRegM = 1'b1; ALUOutM = 32'h0000_0600;
      @(posedge CLK); #1;
      while (MemReq && n < 40) begin
        n++;
        @(posedge CLK); #1;
      end
      chk("to_req_cycles", n, 32'd15);
      chk("to_fault", {31'h0, BusFault}, 32'h1);
      chk("to_rdata", ReadDataM, 32'hDEADBEEF);
      @(posedge CLK); #1;
      MemtoRegM = 1'b0;
      run_access(1'b1, 1'b0, 32'h0000_0704, 32'h0, 2, 32'h0F0F0F0F, stalls, ra, rwe, rdv);
      chk("post_to_rdata", rdv, 32'h0F0F0F0F);
      chk("post_to_fault", {31'h0, BusFault}, 32'h1);
    end
`endif

    repeat (2) @(posedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
